// File: rtl/bus_rr_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_pkg
// Description : Shared definitions for the round-robin bus router:
//               FSM state encoding, destination-ID width and the default
//               broadcast destination.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_rr_pkg;

    // Width of the destination-ID field at the top of every packet
    localparam int ID_W = 8;

    // Destination ID that addresses every terminal except the sender
    localparam logic [ID_W-1:0] BROADCAST_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_ROUTE = 2'd2
    } state_t;

endpackage : bus_rr_pkg
`default_nettype wire

// File: rtl/bus_rr_router_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_router_if
// Description : Terminal-side bus bundle of the round-robin router.
//   pndng  [DRVRS]           per-terminal packet pending      (terminals -> router)
//   D_pop  [DRVRS][PCKG_SZ]  head packet of each terminal      (terminals -> router)
//   pop    [DRVRS]           one-cycle pop strobe to a source  (router -> terminals)
//   push   [DRVRS]           one-cycle push strobe to a dest   (router -> terminals)
//   D_push [PCKG_SZ]         shared delivery bus               (router -> terminals)
//   busy                     transaction in progress           (router -> terminals)
//   err_id                   one-cycle pulse on a dropped pkt  (router -> terminals)
//   modport master : router side;  modport slave : terminal side
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_rr_router_if #(
    parameter int DRVRS   = 4,
    parameter int PCKG_SZ = 16
);
    logic [DRVRS-1:0]              pndng;
    logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop;
    logic [DRVRS-1:0]              pop;
    logic [DRVRS-1:0]              push;
    logic [PCKG_SZ-1:0]            D_push;
    logic                          busy;
    logic                          err_id;

    modport master (
        input  pndng, D_pop,
        output pop, push, D_push, busy, err_id
    );

    modport slave (
        output pndng, D_pop,
        input  pop, push, D_push, busy, err_id
    );

endinterface : bus_rr_router_if
`default_nettype wire

// File: rtl/bus_rr_router_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Searches the request
//               vector starting at last_grant+1 and wrapping around, so the
//               most recently served terminal has the lowest priority.
//   req        [DRVRS]  request vector
//   last_grant [IDX_W]  index of the previous winner
//   gnt_idx    [IDX_W]  index of the selected requester (last_grant if none)
//   any_req             at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int DRVRS = 4,
    localparam int IDX_W = $clog2(DRVRS)
) (
    input  logic [DRVRS-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    int w_cand;

    // Walk from the farthest offset to the nearest; the nearest requester
    // after last_grant is written last and therefore wins.
    always_comb begin
        gnt_idx = last_grant;
        any_req = 1'b0;
        w_cand  = 0;
        for (int i = DRVRS; i >= 1; i--) begin
            w_cand = (int'(last_grant) + i) % DRVRS;
            if (req[w_cand]) begin
                gnt_idx = IDX_W'(w_cand);
                any_req = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bus_rr_router.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_router
// Description : Round-robin packet router for DRVRS bus terminals. A pending
//               terminal is granted in IDLE, its head packet is popped in
//               POP and delivered (or dropped) in ROUTE: three cycles per
//               packet. The top 8 bits of a packet carry the destination ID.
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   bus     bus_rr_router_if.master (pndng, D_pop in; pop, push, D_push,
//           busy, err_id out)
// Options     : define BUS_RR_BCAST_EN to deliver packets addressed to
//               BROADCAST to every terminal except the sender; otherwise such
//               packets are dropped with err_id.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_router
    import bus_rr_pkg::*;
#(
    parameter int              DRVRS     = 4,
    parameter int              PCKG_SZ   = 16,
    parameter logic [ID_W-1:0] BROADCAST = BROADCAST_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_rr_router_if.master       bus
);

    localparam int              IDX_W   = $clog2(DRVRS);
    localparam logic [ID_W-1:0] C_N_ID  = ID_W'(DRVRS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_src;
    logic [IDX_W-1:0]   r_last_grant;
    logic [PCKG_SZ-1:0] r_pkt;
    logic [PCKG_SZ-1:0] r_d_push_hold;

    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_any_req;
    logic [ID_W-1:0]    w_id;
    logic [DRVRS-1:0]   w_uni_mask;
    logic [DRVRS-1:0]   w_bc_mask;
    logic               w_uni_ok;
    logic               w_is_bcast;
    logic               w_deliver;
    logic [DRVRS-1:0]   w_dest;

    logic [DRVRS-1:0]   w_pop;
    logic [DRVRS-1:0]   w_push;
    logic [PCKG_SZ-1:0] w_d_push;
    logic               w_busy;
    logic               w_err;

    rr_arbiter #(
        .DRVRS      (DRVRS)
    ) u_arb (
        .req        (bus.pndng),
        .last_grant (r_last_grant),
        .gnt_idx    (w_gnt_idx),
        .any_req    (w_any_req)
    );

    assign w_id = r_pkt[PCKG_SZ-1 -: ID_W];

    // ------------------------------------------------------------------
    // Destination decode of the latched packet
    // ------------------------------------------------------------------
    always_comb begin
        w_uni_mask = '0;
        w_bc_mask  = '0;
        for (int i = 0; i < DRVRS; i++) begin
            w_uni_mask[i] = (w_id == ID_W'(i));
            w_bc_mask[i]  = (r_src != IDX_W'(i));
        end
        // The broadcast ID is never a unicast target, even if it happens
        // to fall inside the terminal range.
        w_uni_ok = (w_id < C_N_ID) && (w_id != ID_W'(r_src)) && (w_id != BROADCAST);
`ifdef BUS_RR_BCAST_EN
        w_is_bcast = (w_id == BROADCAST);
`else
        w_is_bcast = 1'b0;
`endif
        w_deliver = w_is_bcast || w_uni_ok;
        w_dest    = w_is_bcast ? w_bc_mask : w_uni_mask;
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs. Outputs decode the state register so a
    // reset clears them immediately; D_push falls back to the last
    // delivered packet outside a delivery cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = '0;
        w_push      = '0;
        w_d_push    = r_d_push_hold;
        w_busy      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_POP;
                end
            end
            ST_POP: begin
                w_busy       = 1'b1;
                w_pop[r_src] = 1'b1;
                w_state_nxt  = ST_ROUTE;
            end
            ST_ROUTE: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_IDLE;
                if (w_deliver) begin
                    w_push   = w_dest;
                    w_d_push = r_pkt;
                end else begin
                    w_err    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src         <= '0;
            r_last_grant  <= IDX_W'(DRVRS - 1);   // terminal 0 wins first
            r_pkt         <= '0;
            r_d_push_hold <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_src        <= w_gnt_idx;
                r_last_grant <= w_gnt_idx;
            end
            if (r_state == ST_POP) begin
                r_pkt <= bus.D_pop[r_src];
            end
            if ((r_state == ST_ROUTE) && w_deliver) begin
                r_d_push_hold <= r_pkt;
            end
        end
    end

    assign bus.pop    = w_pop;
    assign bus.push   = w_push;
    assign bus.D_push = w_d_push;
    assign bus.busy   = w_busy;
    assign bus.err_id = w_err;

endmodule : bus_rr_router
`default_nettype wire

// File: doc/bus_rr_router.md
BUS_RR_ROUTER -- requirements
Module: bus_rr_router

Interface
REQ-001 SHALL have parameter DRVRS, default 4, meaning number of bus terminals (2..16).
REQ-002 SHALL have parameter PCKG_SZ, default 16, meaning packet width in bits (>=16).
REQ-003 SHALL have parameter BROADCAST, default 8'hFF, meaning broadcast destination ID.
REQ-004 SHALL use a single clock and an asynchronous active-low reset.
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: pndng  input  DRVRS  per-terminal packet pending.
REQ-008 SHALL have port: D_pop  input  DRVRS x PCKG_SZ  head packet of each terminal.
REQ-009 SHALL have port: pop  output  DRVRS  one-cycle pop strobe to a source.
REQ-010 SHALL have port: push  output  DRVRS  one-cycle push strobe to a destination.
REQ-011 SHALL have port: D_push  output  PCKG_SZ  shared delivery bus.
REQ-012 SHALL have port: busy  output  1  transaction in progress.
REQ-013 SHALL have port: err_id  output  1  one-cycle pulse when a packet is dropped.

Function
REQ-014 SHALL treat packet bits [PCKG_SZ-1 -: 8] as destination ID and the remaining bits as payload.
REQ-015 SHALL implement an FSM with states IDLE, POP and ROUTE.
REQ-016 IDLE: if any pndng bit is high, SHALL select a winner by round-robin starting at last_grant+1, register it as src, and go to POP; otherwise SHALL stay in IDLE.
REQ-017 POP: SHALL assert pop[src] for exactly one cycle, latch D_pop[src] into pkt, and go to ROUTE.
REQ-018 ROUTE, valid unicast (id<DRVRS and id!=src): SHALL assert push[id] for one cycle, drive D_push=pkt, and go to IDLE.
REQ-019 ROUTE, otherwise (id>=DRVRS, id==src, or non-enabled broadcast): SHALL assert no push, pulse err_id for one cycle, and go to IDLE.
REQ-020 Latency SHALL be pndng seen in IDLE at cycle N, pop at N+1, push at N+2; next arbitration at N+3, giving a 3-cycle throughput per packet.
REQ-021 pndng SHALL be sampled only in IDLE; a deasserted pndng[src] during POP SHALL still be popped, since sources hold pndng until popped.
REQ-022 last_grant SHALL update to src on entry to POP; no terminal SHALL wait more than DRVRS grants.
REQ-023 D_push SHALL hold the last delivered packet between pushes.
REQ-024 busy SHALL be high in POP and ROUTE and low in IDLE.
REQ-025 At most one pop bit SHALL be high in any cycle.

Reset
REQ-026 On reset low, the FSM SHALL enter IDLE asynchronously.
REQ-027 On reset low: pop=0, push=0, D_push=0, busy=0, err_id=0, pkt=0, src=0, last_grant=DRVRS-1 (port 0 wins first).
REQ-028 Reset during POP or ROUTE SHALL abort the transaction; an already-popped packet is lost and no push is issued.

Configuration
REQ-029 Macro BUS_RR_BCAST_EN defined: id==BROADCAST in ROUTE SHALL assert push on all terminals except src in the same cycle, with D_push=pkt and no err_id.
REQ-030 Macro BUS_RR_BCAST_EN undefined: id==BROADCAST SHALL be treated as invalid per REQ-019.

Structure
REQ-031 Package bus_rr_pkg SHALL hold the FSM state enum, ID_W=8, and the default BROADCAST constant.
REQ-032 Sub-module rr_arbiter SHALL implement DRVRS-wide round-robin selection: inputs req and last_grant; outputs gnt_idx and any_req.

Verification (DRVRS=4, PCKG_SZ=16)
REQ-033 Unicast: pndng=4'b0001, D_pop[0]=16'h02A5 -> pop=4'b0001 at N+1; push=4'b0100 with D_push=16'h02A5 at N+2; err_id=0.
REQ-034 Fairness: pndng=4'b1111 held, each packet addressed to (src+1)%4 -> pops in order 0,1,2,3,0, one every 3 cycles.
REQ-035 Invalid ID: D_pop[1]=16'h0733 -> pop[1] pulses, no push, err_id pulses at N+2; same for D_pop[1]=16'h0133 (self-addressed).
REQ-036 Broadcast: D_pop[2]=16'hFF11 -> with BUS_RR_BCAST_EN, push=4'b1011 and D_push=16'hFF11; without it, push=0 and err_id=1.
REQ-037 Reset mid-op: assert reset in the ROUTE cycle -> push stays 0, all outputs 0 asynchronously; after release with pndng=4'b0100, port 2 is granted with first pop 2 cycles after the release edge.
